// File: rtl/mpa_debug_pkg.sv
// mpa_debug_pkg
// Shared types and default sizes for the mpa_mips_32 debug port.
//   dbg_func_e  : debug_func target codes
//   dbg_state_e : responder FSM states
//   DEF_*       : default target capacities and acknowledge timeout
package mpa_debug_pkg;

    typedef enum logic [1:0] {
        DBG_DM   = 2'd0,
        DBG_IM   = 2'd1,
        DBG_MR   = 2'd2,
        DBG_RSVD = 2'd3
    } dbg_func_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HALT   = 3'd1,
        READY  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } dbg_state_e;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_IM_CAPACITY   = 64;
    localparam int DEF_DM_CAPACITY   = 128;
    localparam int DEF_MR_CAPACITY   = 32;
    localparam int DEF_ACK_TIMEOUT   = 16;

endpackage

// File: rtl/mpa_debug_timeout.sv
// mpa_debug_timeout
// Loadable down-counter used to bound the wait for tgt_ack.
// Ports:
//   CLK, HW_RSTn : clock, asynchronous active-low reset
//   load         : preload ACK_TIMEOUT-1 (first cycle of an access)
//   en           : count down while the access is outstanding
//   expired      : terminal count reached (counter at zero)
module mpa_debug_timeout #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic HW_RSTn,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge HW_RSTn) begin
        if (!HW_RSTn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mpa_debug_port.sv
// mpa_debug_port
// Responder end of the mpa_mips_32 debug interface. Halts the core, decodes
// debug_func, performs one req/ack transfer to IM, DM or the register file,
// and returns read data on dout.
// Ports:
//   CLK, HW_RSTn             : clock, asynchronous active-low reset
//   mem_debug                : debug session enable (level)
//   debug_func/re/we/addr/din: request from the debug pins
//   dout, dbg_ready, dbg_err : read data, idle flag, sticky error of last access
//   core_halt_req/core_halted: pipeline freeze handshake
//   tgt_*                    : single-transfer bus to the IM/DM/MR debug muxes
// Build option: define MPA_DBG_BOUNDS_CHECK_EN to reject out-of-range indices
// instead of wrapping them to the target capacity.
//
// state  | meaning
// IDLE   | no session, core running
// HALT   | halt requested, waiting for core_halted
// READY  | halted, dbg_ready=1, accepting a request
// ACCESS | tgt_req held until tgt_ack or timeout
// DONE   | one-cycle gap, then READY (or IDLE if the session ended)
module mpa_debug_port
    import mpa_debug_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int IM_CAPACITY   = DEF_IM_CAPACITY,
    parameter int DM_CAPACITY   = DEF_DM_CAPACITY,
    parameter int MR_CAPACITY   = DEF_MR_CAPACITY,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic                     CLK,
    input  logic                     HW_RSTn,
    input  logic                     mem_debug,
    input  logic [1:0]               debug_func,
    input  logic                     debug_re,
    input  logic                     debug_we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dbg_ready,
    output logic                     dbg_err,
    output logic                     core_halt_req,
    input  logic                     core_halted,
    output logic [1:0]               tgt_sel,
    output logic                     tgt_req,
    output logic                     tgt_we,
    output logic [ADDRESS_WIDTH-1:0] tgt_addr,
    output logic [DATA_WIDTH-1:0]    tgt_wdata,
    input  logic                     tgt_ack,
    input  logic [DATA_WIDTH-1:0]    tgt_rdata
);

    // Capacities are powers of two, so wrap-around is a mask.
    localparam logic [ADDRESS_WIDTH-1:0] IM_MASK = ADDRESS_WIDTH'(IM_CAPACITY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] DM_MASK = ADDRESS_WIDTH'(DM_CAPACITY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] MR_MASK = ADDRESS_WIDTH'(MR_CAPACITY - 1);

    dbg_state_e                state, state_nxt;
    logic [DATA_WIDTH-1:0]     dout_nxt, wdata_nxt;
    logic [ADDRESS_WIDTH-1:0]  addr_nxt, word_idx, req_index;
    logic [1:0]                sel_nxt;
    logic                      err_nxt, we_nxt;
    logic                      out_of_range;
    logic                      to_load, to_expired;

    assign word_idx = addr >> 2;

    always_comb begin
        req_index = '0;
        case (debug_func)
            DBG_DM:  req_index = word_idx & DM_MASK;
            DBG_IM:  req_index = word_idx & IM_MASK;
            DBG_MR:  req_index = addr & MR_MASK;
            default: req_index = '0;
        endcase
    end

`ifdef MPA_DBG_BOUNDS_CHECK_EN
    always_comb begin
        out_of_range = 1'b0;
        case (debug_func)
            DBG_DM:  out_of_range = (word_idx >= ADDRESS_WIDTH'(DM_CAPACITY));
            DBG_IM:  out_of_range = (word_idx >= ADDRESS_WIDTH'(IM_CAPACITY));
            DBG_MR:  out_of_range = (addr >= ADDRESS_WIDTH'(MR_CAPACITY));
            default: out_of_range = 1'b0;
        endcase
    end
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        dout_nxt  = dout;
        err_nxt   = dbg_err;
        sel_nxt   = tgt_sel;
        addr_nxt  = tgt_addr;
        wdata_nxt = tgt_wdata;
        we_nxt    = tgt_we;
        case (state)
            IDLE: begin
                if (mem_debug) state_nxt = HALT;
            end
            HALT: begin
                if (!mem_debug)      state_nxt = IDLE;
                else if (core_halted) state_nxt = READY;
            end
            READY: begin
                if (!mem_debug) begin
                    state_nxt = IDLE;
                end else if (debug_we || debug_re) begin
                    sel_nxt   = debug_func;
                    addr_nxt  = req_index;
                    wdata_nxt = din;
                    we_nxt    = debug_we;   // write wins when both are set
                    if ((debug_func == DBG_RSVD) || out_of_range) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle still counts as success.
                if (tgt_ack) begin
                    if (!tgt_we) dout_nxt = tgt_rdata;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (to_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = mem_debug ? READY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Halt stays asserted through DONE, so it can only drop after tgt_req has.
    always_ff @(posedge CLK or negedge HW_RSTn) begin
        if (!HW_RSTn) begin
            state         <= IDLE;
            dout          <= '0;
            dbg_ready     <= 1'b0;
            dbg_err       <= 1'b0;
            core_halt_req <= 1'b0;
            tgt_req       <= 1'b0;
            tgt_we        <= 1'b0;
            tgt_sel       <= '0;
            tgt_addr      <= '0;
            tgt_wdata     <= '0;
        end else begin
            state         <= state_nxt;
            dout          <= dout_nxt;
            dbg_ready     <= (state_nxt == READY);
            dbg_err       <= err_nxt;
            core_halt_req <= (state_nxt != IDLE);
            tgt_req       <= (state_nxt == ACCESS);
            tgt_we        <= we_nxt;
            tgt_sel       <= sel_nxt;
            tgt_addr      <= addr_nxt;
            tgt_wdata     <= wdata_nxt;
        end
    end

    assign to_load = (state != ACCESS) && (state_nxt == ACCESS);

    mpa_debug_timeout #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .HW_RSTn (HW_RSTn),
        .load    (to_load),
        .en      (state == ACCESS),
        .expired (to_expired)
    );

endmodule

// File: tb/tb_mpa_debug_port.sv
// tb_mpa_debug_port
// Scoreboard bench for mpa_debug_port: stimulus pushes expected target
// transfers and expected responses; monitors pop and compare them.
module tb_mpa_debug_port;

    logic        CLK = 1'b0;
    logic        HW_RSTn;
    logic        mem_debug;
    logic [1:0]  debug_func;
    logic        debug_re, debug_we;
    logic [31:0] addr, din, dout;
    logic        dbg_ready, dbg_err, core_halt_req, core_halted;
    logic [1:0]  tgt_sel;
    logic        tgt_req, tgt_we, tgt_ack;
    logic [31:0] tgt_addr, tgt_wdata, tgt_rdata;

    always #5 CLK = ~CLK;

    mpa_debug_port dut (
        .CLK(CLK), .HW_RSTn(HW_RSTn), .mem_debug(mem_debug),
        .debug_func(debug_func), .debug_re(debug_re), .debug_we(debug_we),
        .addr(addr), .din(din), .dout(dout), .dbg_ready(dbg_ready),
        .dbg_err(dbg_err), .core_halt_req(core_halt_req),
        .core_halted(core_halted), .tgt_sel(tgt_sel), .tgt_req(tgt_req),
        .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } tgt_exp_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } rsp_exp_t;

    tgt_exp_t tgt_q[$];
    rsp_exp_t rsp_q[$];

    int n_pass = 0;
    int n_total = 0;

    int          ack_delay = -1;
    logic [31:0] rsp_rdata = '0;
    int          req_run = 0;
    int          last_req_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Target model: acks after ack_delay cycles of tgt_req (-1 = never).
    initial begin
        tgt_ack   = 1'b0;
        tgt_rdata = '0;
        forever begin
            @(negedge CLK);
            if (tgt_req) begin
                if (ack_delay >= 0 && req_run == ack_delay) begin
                    tgt_ack   = 1'b1;
                    tgt_rdata = rsp_rdata;
                end else begin
                    tgt_ack = 1'b0;
                end
                req_run++;
            end else begin
                tgt_ack = 1'b0;
                if (req_run > 0) last_req_len = req_run;
                req_run = 0;
            end
        end
    end

    // Target-side monitor: each new tgt_req must match the next expected transfer.
    initial begin
        logic prev_req;
        tgt_exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            if (tgt_req && !prev_req) begin
                if (tgt_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tgt_unexpected: tgt_req with sel=%0d addr=%0h, none expected",
                             tgt_sel, tgt_addr);
                end else begin
                    e = tgt_q.pop_front();
                    check("tgt_sel",   32'(tgt_sel), 32'(e.sel));
                    check("tgt_addr",  tgt_addr,     e.addr);
                    check("tgt_we",    32'(tgt_we),  32'(e.we));
                    check("tgt_wdata", tgt_wdata,    e.wdata);
                end
            end
            prev_req = tgt_req;
        end
    end

    // Response monitor: completion is dbg_ready rising or the halt being released.
    initial begin
        logic prev_ready, prev_halt;
        rsp_exp_t e;
        prev_ready = 1'b0;
        prev_halt  = 1'b0;
        forever begin
            @(negedge CLK);
            if (HW_RSTn && ((dbg_ready && !prev_ready) || (!core_halt_req && prev_halt))
                && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                check("dout",    dout,          e.dout);
                check("dbg_err", 32'(dbg_err),  32'(e.err));
            end
            prev_ready = dbg_ready;
            prev_halt  = core_halt_req;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!dbg_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!dbg_ready) check("wait_ready_timeout", 32'(dbg_ready), 32'd1);
    endtask

    task automatic do_access(input logic [1:0] func, input logic [31:0] a, input logic we,
                             input logic [31:0] d, input int delay, input logic [31:0] rdata,
                             input logic exp_tgt, input logic [31:0] exp_taddr,
                             input logic [31:0] exp_dout, input logic exp_err, output int lat);
        @(negedge CLK);
        wait_ready();
        ack_delay = delay;
        rsp_rdata = rdata;
        if (exp_tgt) tgt_q.push_back('{sel: func, addr: exp_taddr, we: we, wdata: d});
        rsp_q.push_back('{dout: exp_dout, err: exp_err});
        debug_func = func;
        addr       = a;
        din        = d;
        debug_we   = we;
        debug_re   = !we;
        @(posedge CLK);
        #1;
        debug_we = 1'b0;
        debug_re = 1'b0;
        lat = 0;
        while (!dbg_ready && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        if (!dbg_ready) check("access_ready_timeout", 32'(dbg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        logic halt_viol;

        HW_RSTn = 1'b0; mem_debug = 1'b1; core_halted = 1'b0;
        debug_func = 2'd0; debug_re = 1'b0; debug_we = 1'b0; addr = '0; din = '0;

        repeat (3) @(negedge CLK);
        check("rst_dout",          dout,                '0);
        check("rst_dbg_ready",     32'(dbg_ready),      32'd0);
        check("rst_dbg_err",       32'(dbg_err),        32'd0);
        check("rst_core_halt_req", 32'(core_halt_req),  32'd0);
        check("rst_tgt_req",       32'(tgt_req),        32'd0);
        check("rst_tgt_we",        32'(tgt_we),         32'd0);
        check("rst_tgt_sel",       32'(tgt_sel),        32'd0);
        check("rst_tgt_addr",      tgt_addr,            '0);
        check("rst_tgt_wdata",     tgt_wdata,           '0);

        HW_RSTn = 1'b1;
        @(negedge CLK);
        check("halt_req_after_release", 32'(core_halt_req), 32'd1);
        check("ready_before_halted",    32'(dbg_ready),     32'd0);
        core_halted = 1'b1;
        @(negedge CLK);
        check("ready_after_halted",     32'(dbg_ready),     32'd1);

        // IM read, ack one cycle late
        do_access(2'd1, 32'd8, 1'b0, 32'd0, 1, 32'h2002_0005,
                  1'b1, 32'd2, 32'h2002_0005, 1'b0, lat);

        // MR write, zero-wait ack; dout keeps the previous read
        do_access(2'd2, 32'd5, 1'b1, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF,
                  1'b1, 32'd5, 32'h2002_0005, 1'b0, lat);
        check("latency_zero_wait", lat, 32'd3);

        // DM read with no ack: timeout after 16 request cycles
        do_access(2'd0, 32'h10, 1'b0, 32'd0, -1, 32'h0,
                  1'b1, 32'd4, 32'h2002_0005, 1'b1, lat);
        check("timeout_req_cycles", last_req_len, 32'd16);

        // last DM word; a good read clears the error
        do_access(2'd0, 32'h1FC, 1'b0, 32'd0, 0, 32'h1234_5678,
                  1'b1, 32'h7F, 32'h1234_5678, 1'b0, lat);

        // reserved function: no transfer, error set
        do_access(2'd3, 32'd4, 1'b0, 32'd0, 0, 32'h0,
                  1'b0, 32'd0, 32'h1234_5678, 1'b1, lat);
        check("latency_reserved", lat, 32'd2);

`ifdef MPA_DBG_BOUNDS_CHECK_EN
        do_access(2'd1, 32'd256, 1'b0, 32'd0, 0, 32'hA5A5_0001,
                  1'b0, 32'd0, 32'h1234_5678, 1'b1, lat);
        do_access(2'd2, 32'd37, 1'b1, 32'h0000_0077, 0, 32'h0,
                  1'b0, 32'd0, 32'h1234_5678, 1'b1, lat);
`else
        do_access(2'd1, 32'd256, 1'b0, 32'd0, 0, 32'hA5A5_0001,
                  1'b1, 32'd0, 32'hA5A5_0001, 1'b0, lat);
        do_access(2'd2, 32'd37, 1'b1, 32'h0000_0077, 0, 32'h0,
                  1'b1, 32'd5, 32'hA5A5_0001, 1'b0, lat);
`endif

        // session ends mid-access; ack 4 cycles late
        @(negedge CLK);
        wait_ready();
        ack_delay = 4;
        rsp_rdata = 32'h0BAD_CAFE;
        tgt_q.push_back('{sel: 2'd1, addr: 32'd3, we: 1'b0, wdata: 32'd0});
        rsp_q.push_back('{dout: 32'h0BAD_CAFE, err: 1'b0});
        debug_func = 2'd1; addr = 32'hC; din = 32'd0; debug_re = 1'b1;
        @(posedge CLK);
        #1;
        debug_re = 1'b0;
        @(negedge CLK);
        mem_debug = 1'b0;
        n = 0;
        halt_viol = 1'b0;
        while (core_halt_req && n < 50) begin
            @(negedge CLK);
            if (tgt_req && !core_halt_req) halt_viol = 1'b1;
            n++;
        end
        check("halt_released_with_req", 32'(halt_viol), 32'd0);
        check("release_cycles",         n,              32'd6);
        check("tgt_req_at_release",     32'(tgt_req),   32'd0);
        check("ready_after_session",    32'(dbg_ready), 32'd0);
        core_halted = 1'b0;

        repeat (3) @(negedge CLK);
        check("tgt_q_left", tgt_q.size(), 32'd0);
        check("rsp_q_left", rsp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
